// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the synchronous FIFO: turns the one-cycle FIFO read latency into a
// valid/ready stream with a 2-entry skid buffer, frame delimiting and an enable/drain FSM.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [15:0] LastBeat = 16'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [15:0]      beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop, capture, issue_ok;

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign capture   = inflight_q;
  assign issue_ok  = (state_q == StRun);

  // A pop this cycle frees a slot for the word that lands two edges from now.
  assign fifo_rd_en = issue_ok & ~fifo_empty &
                      ((({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2) | pop);

  assign out_data = out_valid ? buf_q[head_q] : '0;
  assign out_last = out_valid & (beat_q == LastBeat);
  assign word_cnt = cnt_q;
  assign busy     = (state_q != StIdle);

  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    inflight_d = fifo_rd_en;
    if (capture) begin
      tail_d = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + CNT_W'(1);
      beat_d = (beat_q == LastBeat) ? 16'd0 : beat_q + 16'd1;
    end
    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StRun;
      end
      StRun: begin
        if (!en) state_d = StDrain;
      end
      StDrain: begin
        if (en) begin
          state_d = StRun;
        end else if ((occ_d == 2'd0) && !inflight_d) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      beat_q     <= 16'd0;
      cnt_q      <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      if (capture) begin
        buf_q[tail_q] <= fifo_data_out;
      end
    end
  end

  // The credit rule keeps occ + inflight <= 2, so a landing word always finds a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(capture && (occ_q == 2'd2)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized scoreboard bench for fifo_rd_stream with a behavioural FIFO in front of it and a
// second instance (FRAME_LEN=1, CNT_W=4) sharing the same stimulus.
module tb_fifo_rd_stream;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned CW2       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic             out_ready = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data_out = '0;
  logic             fifo_rd_en, out_valid, out_last, busy;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] word_cnt;
  logic             fifo_rd_en2, out_valid2, out_last2, busy2;
  logic [WIDTH-1:0] out_data2;
  logic [CW2-1:0]   word_cnt2;

  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  int unsigned      rd_count = 0;
  int unsigned      rd_idx = 0;
  int unsigned      n = 0;
  int unsigned      rd_base = 0;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .word_cnt(word_cnt),
    .busy(busy)
  );

  fifo_rd_stream #(.WIDTH(WIDTH), .FRAME_LEN(1), .CNT_W(CW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2), .word_cnt(word_cnt2),
    .busy(busy2)
  );

  // Behavioural synchronous FIFO: registered empty flag, one-cycle read latency, shares rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_empty    <= 1'b1;
      fifo_data_out <= '0;
    end else begin
      if (fifo_rd_en && !fifo_empty) begin
        fifo_data_out <= fq.pop_front();
        rd_count      <= rd_count + 1;
      end
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: words must come out in write order; reset discards everything written so far.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_idx  = exp_q.size();
        n       = 0;
        rd_base = rd_count;
      end else begin
        if (fifo_rd_en)  check("underflow", {63'd0, fifo_empty}, 64'd0);
        if (fifo_rd_en2) check("underflow2", {63'd0, fifo_empty}, 64'd0);
        check("credit", {63'd0, (rd_count - rd_base - n) <= 2}, 64'd1);
        if (out_valid) begin
          if (rd_idx < exp_q.size()) begin
            check("data", 64'(out_data), 64'(exp_q[rd_idx]));
            check("last", {63'd0, out_last}, {63'd0, (n % FRAME_LEN) == FRAME_LEN - 1});
            check("word_cnt", 64'(word_cnt), 64'(n));
          end else begin
            check("spurious_valid", 64'd1, 64'd0);
          end
        end
        if (out_valid2 && rd_idx < exp_q.size()) begin
          check("data2", 64'(out_data2), 64'(exp_q[rd_idx]));
          check("last2", {63'd0, out_last2}, 64'd1);
          check("word_cnt2", 64'(word_cnt2), 64'(n % 16));
        end
        if (out_valid && out_ready) begin
          rd_idx++;
          n++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input bit toggle);
    int k = 0;
    while ((rd_idx != exp_q.size() || fq.size() != 0) && k < 400) begin
      cyc();
      if (toggle) out_ready = ~out_ready;
      k++;
    end
    check("drain_in_time", {63'd0, k < 400}, 64'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    int unsigned rd0, rd1, reads;
    int k;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_cnt", 64'(word_cnt), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_busy2", {63'd0, busy2}, 64'd0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Streaming with constant ready.
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) write_word(WIDTH'(i));
    wait_drain(1'b0);
    check("p1_word_cnt", 64'(word_cnt), 64'd20);

    // Sink stalled: only two words may be pulled.
    out_ready = 1'b0;
    rd0 = rd_count;
    for (int i = 1; i <= 5; i++) write_word(WIDTH'(i));
    repeat (10) cyc();
    check("p2_reads", 64'(rd_count - rd0), 64'd2);
    check("p2_valid", {63'd0, out_valid}, 64'd1);
    check("p2_head", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    wait_drain(1'b0);
    check("p2_fifo_empty", {63'd0, fifo_empty}, 64'd1);
    check("p2_word_cnt", 64'(word_cnt), 64'd25);

    // Toggling ready.
    for (int i = 0; i < 16; i++) begin
      out_ready = ~out_ready;
      write_word(WIDTH'($urandom));
    end
    wait_drain(1'b1);
    check("p3_word_cnt", 64'(word_cnt), 64'd41);

    // Drop en one cycle after a read issue.
    en = 1'b0;
    repeat (3) cyc();
    check("p4_idle", {63'd0, busy}, 64'd0);
    rd0 = rd_count;
    for (int i = 0; i < 6; i++) write_word(WIDTH'(16'h0300 + i));
    check("p4_no_read_idle", 64'(rd_count - rd0), 64'd0);
    en = 1'b1;
    k = 0;
    while (rd_count == rd0 && k < 20) begin
      cyc();
      k++;
    end
    en = 1'b0;
    cyc();
    check("p4_drain_busy", {63'd0, busy}, 64'd1);
    check("p4_drain_no_rd", {63'd0, fifo_rd_en}, 64'd0);
    k = 0;
    while (busy && k < 50) begin
      cyc();
      k++;
    end
    check("p4_back_idle", {63'd0, busy}, 64'd0);
    reads = rd_count - rd0;
    check("p4_reads", 64'(reads), 64'd2);
    check("p4_delivered", 64'(exp_q.size() - rd_idx), 64'(6 - reads));
    rd1 = rd_count;
    repeat (5) cyc();
    check("p4_no_more_reads", 64'(rd_count - rd1), 64'd0);
    en = 1'b1;
    wait_drain(1'b0);

    // Reset mid-operation with a full buffer.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(WIDTH'(16'h0400 + i));
    repeat (4) cyc();
    check("p5_full", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("p5_valid", {63'd0, out_valid}, 64'd0);
    check("p5_data", 64'(out_data), 64'd0);
    check("p5_cnt", 64'(word_cnt), 64'd0);
    check("p5_busy", {63'd0, busy}, 64'd0);
    check("p5_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) write_word(WIDTH'(16'h0200 + i));
    wait_drain(1'b0);
    check("p5_word_cnt", 64'(word_cnt), 64'd18);
    check("p5_word_cnt2", 64'(word_cnt2), 64'd2);

    // Random ready / en / write mix.
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) != 0) write_word(WIDTH'($urandom));
      else cyc();
    end
    en = 1'b1;
    wait_drain(1'b0);
    check("p6_word_cnt", 64'(word_cnt), 64'(n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
